// File: rtl/isr_ctrl.sv
// Interrupt cause collector and JISR/ERET sequencer: synchronises device events, masks causes
// with sr, resolves priority and sequences the jisr/eret pulses and pipeline stall.
module isr_ctrl #(
  parameter int N_EXT        = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [5:0]       int_ev,
  input  logic [N_EXT-1:0] ext_ev,
  input  logic [31:0]      sr,
  input  logic             eret_req,
  output logic             jisr,
  output logic             eret,
  output logic [22:0]      mca,
  output logic             rpt,
  output logic             stall,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {IDLE, JISR, FLUSH, ERET} state_t;

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             rst_pend;
  logic [N_EXT-1:0] sync_q [SYNC_STAGES];
  logic [N_EXT-1:0] sync_d;
  logic [N_EXT-1:0] pend;
  logic [N_EXT-1:0] ext_rise;
  logic [N_EXT-1:0] pend_clr;
  logic [22:0]      ca;
  logic [22:0]      mc;
  logic             take;
  logic             rpt_nxt;
  logic             unused_sr;

  assign unused_sr = ^{sr[31:23], sr[5:0]};

  // Synchroniser chain per line; the extra sync_d stage provides the rising-edge reference.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      sync_d <= '0;
    end else begin
      sync_q[0] <= ext_ev;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sync_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign ext_rise = sync_q[SYNC_STAGES-1] & ~sync_d;

  always_comb begin
    ca = '0;
    ca[0] = rst_pend;
    ca[6:1] = int_ev & {6{instr_valid}};
    ca[7 +: N_EXT] = pend;
  end

  // Causes 0..5 cannot be masked; 6..22 are enabled by the matching sr bit.
  assign mc = ca & {sr[22:6], 6'h3f};

  assign take = (state == IDLE) && (|mc);
  assign rpt_nxt = (mc[3] && (mc[2:0] == 3'b000)) || (mc[4] && (mc[3:0] == 4'b0000));
  assign pend_clr = take ? mc[7 +: N_EXT] : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (take) state_nxt = JISR;
        else if (eret_req) state_nxt = ERET;
      end
      JISR:  state_nxt = FLUSH;
      FLUSH: if (cnt == CW'(FLUSH_CYCLES - 1)) state_nxt = IDLE;
      ERET:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      mca      <= '0;
      rpt      <= 1'b0;
      rst_pend <= 1'b1;
      pend     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == FLUSH) ? cnt + 1'b1 : '0;
      // A rise landing in the capture cycle is OR-ed after the clear so it is not lost.
      pend  <= (pend & ~pend_clr) | ext_rise;
      if (take) begin
        mca      <= mc;
        rpt      <= rpt_nxt;
        rst_pend <= 1'b0;
      end
    end
  end

  // jisr/eret are single-cycle strobes with no back-pressure; mca/rpt are meaningful only while jisr=1.
  assign jisr      = (state == JISR);
  assign eret      = (state == ERET);
  assign stall     = (state != IDLE);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_isr_ctrl.sv
// Bench for isr_ctrl: directed scenarios plus random traffic, every cycle compared against
// a behavioural cause/stall model.
module tb_isr_ctrl;
  localparam int N_EXT = 16;
  localparam int F     = 2;
  localparam int S     = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             instr_valid = 1'b0;
  logic [5:0]       int_ev = '0;
  logic [N_EXT-1:0] ext_ev = '0;
  logic [31:0]      sr = '0;
  logic             eret_req = 1'b0;
  logic             jisr, eret, rpt, stall, busy;
  logic [22:0]      mca;
  logic [1:0]       state_dbg;

  int checks = 0;
  int errors = 0;

  isr_ctrl #(.N_EXT(N_EXT), .FLUSH_CYCLES(F), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .int_ev(int_ev), .ext_ev(ext_ev),
    .sr(sr), .eret_req(eret_req), .jisr(jisr), .eret(eret), .mca(mca), .rpt(rpt),
    .stall(stall), .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: pending causes plus a count of remaining stall cycles.
  int               m_stall_left = 0;
  logic             m_rst_pend = 1'b1;
  logic [N_EXT-1:0] m_pend = '0;
  logic [N_EXT-1:0] m_hist [0:S];
  logic             m_jisr = 1'b0, m_eret = 1'b0, m_rpt = 1'b0;
  logic [22:0]      m_mca = '0;

  always @(posedge clk) begin
    logic [N_EXT-1:0] rise;
    logic [22:0] cav, mcv;
    int prim;
    if (!rst_n) begin
      m_stall_left = 0; m_rst_pend = 1'b1; m_pend = '0;
      m_jisr = 1'b0; m_eret = 1'b0; m_rpt = 1'b0; m_mca = '0;
      for (int i = 0; i <= S; i++) m_hist[i] = '0;
    end else begin
      rise = m_hist[S-1] & ~m_hist[S];
      cav = '0;
      cav[0] = m_rst_pend;
      for (int j = 1; j <= 6; j++) cav[j] = instr_valid && int_ev[j-1];
      for (int j = 0; j < N_EXT; j++) cav[7+j] = m_pend[j];
      for (int j = 0; j < 23; j++) mcv[j] = cav[j] && (j <= 5 || sr[j]);
      m_jisr = 1'b0;
      m_eret = 1'b0;
      if (m_stall_left == 0) begin
        if (mcv != 0) begin
          prim = -1;
          for (int j = 22; j >= 0; j--) if (mcv[j]) prim = j;
          m_jisr = 1'b1;
          m_mca = mcv;
          m_rpt = (prim == 3 || prim == 4);
          m_rst_pend = 1'b0;
          for (int j = 0; j < N_EXT; j++) if (mcv[7+j]) m_pend[j] = 1'b0;
          m_stall_left = F + 1;
        end else if (eret_req) begin
          m_eret = 1'b1;
          m_stall_left = 1;
        end
      end else begin
        m_stall_left--;
      end
      m_pend = m_pend | rise;
      for (int i = S; i >= 1; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = ext_ev;
    end
    #1;
    check("model_jisr", 32'(jisr), 32'(m_jisr));
    check("model_eret", 32'(eret), 32'(m_eret));
    check("model_mca", 32'(mca), 32'(m_mca));
    check("model_rpt", 32'(rpt), 32'(m_rpt));
    check("model_stall", 32'(stall), 32'(m_stall_left != 0));
    check("model_busy", 32'(busy), 32'(m_stall_left != 0));
  end

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clear_inputs();
    instr_valid = 1'b0; int_ev = '0; eret_req = 1'b0; ext_ev = '0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (m_stall_left != 0 && k < 20) begin cyc(); k++; end
    check("wait_idle_timeout", 32'(k < 20), 32'd1);
    cyc();
  endtask

  task automatic fire_ill();
    instr_valid = 1'b1; int_ev = 6'b000001;
    cyc();
    clear_inputs();
  endtask

  initial begin
    int cnt;
    // 1: reset and release
    cyc(3);
    check("rst_jisr", 32'(jisr), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mca", 32'(mca), 32'd0);
    rst_n = 1'b1;
    cyc();
    check("t1_jisr", 32'(jisr), 32'd1);
    check("t1_mca", 32'(mca), 32'h1);
    check("t1_rpt", 32'(rpt), 32'd0);
    check("t1_stall0", 32'(stall), 32'd1);
    for (int i = 0; i < F; i++) begin cyc(); check("t1_stall_flush", 32'(stall), 32'd1); end
    cyc();
    check("t1_busy_done", 32'(busy), 32'd0);

    // 2: pff alone, then pff+mal
    instr_valid = 1'b1; int_ev = 6'b000100;
    cyc(); clear_inputs();
    check("t2_jisr", 32'(jisr), 32'd1);
    check("t2_mca", 32'(mca), 32'h8);
    check("t2_rpt", 32'(rpt), 32'd1);
    wait_idle();
    instr_valid = 1'b1; int_ev = 6'b000110;
    cyc(); clear_inputs();
    check("t2b_mca", 32'(mca), 32'hC);
    check("t2b_rpt", 32'(rpt), 32'd0);
    wait_idle();

    // 3: masked external event, then unmasked
    sr = '0; ext_ev[0] = 1'b1;
    cyc(3); ext_ev = '0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin cyc(); cnt += int'(jisr); end
    check("t3_masked_jisrs", 32'(cnt), 32'd0);
    sr[7] = 1'b1;
    cyc();
    check("t3_jisr", 32'(jisr), 32'd1);
    check("t3_mca", 32'(mca), 32'h80);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin cyc(); cnt += int'(jisr); end
    check("t3_no_second", 32'(cnt), 32'd0);
    sr = '0;

    // 4: eret alone, then eret with ill
    eret_req = 1'b1;
    cyc(); clear_inputs();
    check("t4_eret", 32'(eret), 32'd1);
    check("t4_stall", 32'(stall), 32'd1);
    cyc();
    check("t4_eret_off", 32'(eret), 32'd0);
    check("t4_stall_off", 32'(stall), 32'd0);
    eret_req = 1'b1; instr_valid = 1'b1; int_ev = 6'b000001;
    cyc(); clear_inputs();
    check("t4b_jisr", 32'(jisr), 32'd1);
    check("t4b_mca", 32'(mca), 32'h2);
    check("t4b_eret", 32'(eret), 32'd0);
    wait_idle();

    // 5: external edge during flush
    sr[10] = 1'b1;
    fire_ill();
    ext_ev[3] = 1'b1;
    cyc(F + 1);
    check("t5_idle", 32'(busy), 32'd0);
    cyc();
    check("t5_jisr", 32'(jisr), 32'd1);
    check("t5_mca", 32'(mca), 32'h400);
    ext_ev = '0; sr = '0;
    wait_idle();

    // 6: reset during flush
    fire_ill();
    cyc();
    rst_n = 1'b0;
    cyc();
    check("t6_jisr", 32'(jisr), 32'd0);
    check("t6_eret", 32'(eret), 32'd0);
    check("t6_mca", 32'(mca), 32'd0);
    check("t6_rpt", 32'(rpt), 32'd0);
    check("t6_stall", 32'(stall), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    cyc();
    check("t6_rst_jisr", 32'(jisr), 32'd1);
    check("t6_rst_mca", 32'(mca), 32'h1);
    wait_idle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      instr_valid = ($urandom_range(0, 3) == 0);
      int_ev = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
      eret_req = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) ext_ev = ext_ev ^ (N_EXT'(1) << $urandom_range(0, N_EXT - 1));
      if ($urandom_range(0, 15) == 0) sr = $urandom;
      rst_n = ($urandom_range(0, 99) != 0);
      cyc();
    end
    rst_n = 1'b1;
    clear_inputs();
    cyc(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
